// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID-stage hazard sources, memory handshake and pipeline control enables.
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] IFIDRegRs_i;
    logic [REG_AW-1:0] IFIDRegRt_i;
    logic              IDEXMemRead_i;
    logic [REG_AW-1:0] IDEXRegRt_i;
    logic              EXMEMMemRead_i;
    logic [REG_AW-1:0] EXMEMRegRt_i;
    logic              memReq_i;
    logic              memAck_i;
    logic              branchTaken_i;
    logic              pcWrite_o;
    logic              IFID_o;
    logic              IFIDFlush_o;
    logic              MuxSelect_o;
    logic              freeze_o;
    logic              error_o;

    modport master (
        output IFIDRegRs_i, IFIDRegRt_i, IDEXMemRead_i, IDEXRegRt_i,
               EXMEMMemRead_i, EXMEMRegRt_i, memReq_i, memAck_i, branchTaken_i,
        input  pcWrite_o, IFID_o, IFIDFlush_o, MuxSelect_o, freeze_o, error_o
    );

    modport slave (
        input  IFIDRegRs_i, IFIDRegRt_i, IDEXMemRead_i, IDEXRegRt_i,
               EXMEMMemRead_i, EXMEMRegRt_i, memReq_i, memAck_i, branchTaken_i,
        output pcWrite_o, IFID_o, IFIDFlush_o, MuxSelect_o, freeze_o, error_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, memory-wait freeze, branch flush and sticky timeout error.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_stall_ctrl #(
    parameter int REG_AW         = 5,
    parameter int LOAD_USE_DEPTH = 1,
    parameter int TIMEOUT_CYC    = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_stall_ctrl_if.slave  bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]         stallCnt_o,
    output logic [31:0]         flushCnt_o
`endif
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [REG_AW-1:0]  w_rs, w_rt;
    logic               w_lu, w_pc, w_ifid, w_flush, w_mux, w_freeze;

    function automatic logic hit(input logic [REG_AW-1:0] a, rs, rt);
        return (a != '0) && (a == rs || a == rt);
    endfunction

    assign w_rs = bus.IFIDRegRs_i;
    assign w_rt = bus.IFIDRegRt_i;
    assign w_lu = (bus.IDEXMemRead_i & hit(bus.IDEXRegRt_i, w_rs, w_rt))
                | ((LOAD_USE_DEPTH == 2) & bus.EXMEMMemRead_i & hit(bus.EXMEMRegRt_i, w_rs, w_rt));

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_pc      = 1'b1;
        w_ifid    = 1'b1;
        w_flush   = 1'b0;
        w_mux     = 1'b0;
        w_freeze  = 1'b0;
        if (r_state == ERR) begin
            w_pc     = 1'b0;
            w_ifid   = 1'b0;
            w_freeze = 1'b1;
        end else if (r_state == MEM_WAIT) begin
            w_pc     = 1'b0;
            w_ifid   = 1'b0;
            w_freeze = 1'b1;
            if (bus.memAck_i) begin
                w_next    = RUN;
                w_cnt_nxt = '0;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
                w_next = ERR;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (bus.memReq_i && !bus.memAck_i) begin
            w_pc      = 1'b0;
            w_ifid    = 1'b0;
            w_freeze  = 1'b1;
            w_next    = MEM_WAIT;
            w_cnt_nxt = CNT_W'(1);
        end else if (w_lu) begin
            w_pc   = 1'b0;
            w_ifid = 1'b0;
            w_mux  = 1'b1;
        end else begin
            w_flush = bus.branchTaken_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // While reset is held the pipeline is parked with a bubble selected.
    assign bus.pcWrite_o   = rst_i & w_pc;
    assign bus.IFID_o      = rst_i & w_ifid;
    assign bus.IFIDFlush_o = rst_i & w_flush;
    assign bus.MuxSelect_o = ~rst_i | w_mux;
    assign bus.freeze_o    = rst_i & w_freeze;
    assign bus.error_o     = (r_state == ERR);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall, r_flush;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (!w_pc && r_stall != '1) r_stall <= r_stall + 1'b1;
            if (w_flush && r_flush != '1) r_flush <= r_flush + 1'b1;
        end
    end

    assign stallCnt_o = r_stall;
    assign flushCnt_o = r_flush;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random checks of two controller instances (depth 1 / depth 2)
// against a behavioural model of the stall, freeze, flush and timeout rules.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, idex_rt, exmem_rt;
    logic       idex_rd, exmem_rd, req, ack, br;
    int         vectors = 0;
    int         miscompares = 0;

    int         depth [2] = '{1, 2};
    int         tmo   [2] = '{4, 6};
    bit         m_wait[2];
    bit         m_err [2];
    int         m_cnt [2];
    longint     m_stall[2];
    longint     m_flush[2];

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_AW(5)) bus1();
    hazard_stall_ctrl_if #(.REG_AW(5)) bus2();

    assign bus1.IFIDRegRs_i = rs;       assign bus2.IFIDRegRs_i = rs;
    assign bus1.IFIDRegRt_i = rt;       assign bus2.IFIDRegRt_i = rt;
    assign bus1.IDEXMemRead_i = idex_rd;   assign bus2.IDEXMemRead_i = idex_rd;
    assign bus1.IDEXRegRt_i = idex_rt;     assign bus2.IDEXRegRt_i = idex_rt;
    assign bus1.EXMEMMemRead_i = exmem_rd; assign bus2.EXMEMMemRead_i = exmem_rd;
    assign bus1.EXMEMRegRt_i = exmem_rt;   assign bus2.EXMEMRegRt_i = exmem_rt;
    assign bus1.memReq_i = req;         assign bus2.memReq_i = req;
    assign bus1.memAck_i = ack;         assign bus2.memAck_i = ack;
    assign bus1.branchTaken_i = br;     assign bus2.branchTaken_i = br;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall1, flush1, stall2, flush2;
`endif

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_DEPTH(1), .TIMEOUT_CYC(4), .CNT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus1)
`ifdef HAZ_PERF_CNT_EN
        , .stallCnt_o(stall1), .flushCnt_o(flush1)
`endif
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_USE_DEPTH(2), .TIMEOUT_CYC(6), .CNT_W(8)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus2)
`ifdef HAZ_PERF_CNT_EN
        , .stallCnt_o(stall2), .flushCnt_o(flush2)
`endif
    );

    wire logic [5:0] o1 = {bus1.pcWrite_o, bus1.IFID_o, bus1.IFIDFlush_o, bus1.MuxSelect_o, bus1.freeze_o, bus1.error_o};
    wire logic [5:0] o2 = {bus2.pcWrite_o, bus2.IFID_o, bus2.IFIDFlush_o, bus2.MuxSelect_o, bus2.freeze_o, bus2.error_o};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] a);
        return a != 0 && (a == rs || a == rt);
    endfunction

    // Expected {pcWrite, IFID, IFIDFlush, MuxSelect, freeze, error}
    function automatic logic [5:0] exp_out(input int k);
        bit lu;
        lu = (idex_rd && hit(idex_rt)) || (depth[k] == 2 && exmem_rd && hit(exmem_rt));
        if (!rst_n)            return 6'b000100;
        if (m_err[k])          return 6'b000011;
        if (m_wait[k])         return 6'b000010;
        if (req && !ack)       return 6'b000010;
        if (lu)                return 6'b000100;
        if (br)                return 6'b111000;
        return 6'b110000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    task automatic clr();
        rs = 0; rt = 0; idex_rt = 0; exmem_rt = 0;
        idex_rd = 0; exmem_rd = 0; req = 0; ack = 0; br = 0;
    endtask

    task automatic settle(input string tag);
        if (!rst_n) model_reset();
        #2;
        check({tag, "/d1"}, 32'(o1), 32'(exp_out(0)));
        check({tag, "/d2"}, 32'(o2), 32'(exp_out(1)));
`ifdef HAZ_PERF_CNT_EN
        check({tag, "/stall1"}, stall1, 32'(m_stall[0]));
        check({tag, "/flush1"}, flush1, 32'(m_flush[0]));
        check({tag, "/stall2"}, stall2, 32'(m_stall[1]));
        check({tag, "/flush2"}, flush2, 32'(m_flush[1]));
`endif
    endtask

    task automatic tick();
        logic [5:0] e;
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                e = exp_out(k);
                if (!e[5] && m_stall[k] < 64'hFFFFFFFF) m_stall[k]++;
                if (e[3] && m_flush[k] < 64'hFFFFFFFF) m_flush[k]++;
                if (m_err[k]) begin
                end else if (m_wait[k]) begin
                    if (ack) m_wait[k] = 0;
                    else if (m_cnt[k] == tmo[k]) begin m_err[k] = 1; m_wait[k] = 0; end
                    else m_cnt[k]++;
                end else if (req && !ack) begin
                    m_wait[k] = 1; m_cnt[k] = 1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr();
        settle("rst");
        check("rst_pc", 32'(bus1.pcWrite_o), 0);
        check("rst_mux", 32'(bus1.MuxSelect_o), 1);
        tick();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        clr();
        model_reset();
        #1;
        do_reset();

        // load-use on rs, then load moves to MEM: depth 2 keeps stalling
        idex_rd = 1; idex_rt = 5; rs = 5;
        settle("lu_ex");
        check("lu_ex_pc", 32'(bus1.pcWrite_o), 0);
        check("lu_ex_mux", 32'(bus1.MuxSelect_o), 1);
        tick();
        idex_rd = 0; exmem_rd = 1; exmem_rt = 5;
        settle("lu_mem");
        check("lu_mem_pc_d1", 32'(bus1.pcWrite_o), 1);
        check("lu_mem_pc_d2", 32'(bus2.pcWrite_o), 0);
        tick();
        clr();
        // register 0 never hazards
        idex_rd = 1; idex_rt = 0;
        settle("r0");
        check("r0_pc", 32'(bus1.pcWrite_o), 1);
        check("r0_mux", 32'(bus1.MuxSelect_o), 0);
        tick();
        clr();
        // r7 consumer on rt
        idex_rd = 1; idex_rt = 7; rt = 7;
        settle("r7a"); tick();
        idex_rd = 0; exmem_rd = 1; exmem_rt = 7;
        settle("r7b"); tick();
        exmem_rd = 0;
        settle("r7c");
        check("r7c_pc_d2", 32'(bus2.pcWrite_o), 1);
        tick();
        clr();

        // memory wait with ack on third cycle
        req = 1;
        settle("mw0"); check("mw0_frz", 32'(bus1.freeze_o), 1); tick();
        settle("mw1"); tick();
        ack = 1;
        settle("mw2"); check("mw2_frz", 32'(bus1.freeze_o), 1); tick();
        req = 0; ack = 0;
        settle("mw3"); check("mw3_frz", 32'(bus1.freeze_o), 0); check("mw3_pc", 32'(bus1.pcWrite_o), 1); tick();
        req = 1; ack = 1;
        settle("same_ack"); check("same_ack_frz", 32'(bus1.freeze_o), 0); tick();
        clr();

        // timeout into sticky error
        req = 1;
        for (int i = 0; i < 8; i++) begin settle("tmo"); tick(); end
        settle("err");
        check("err_d1", 32'(bus1.error_o), 1);
        check("err_d2", 32'(bus2.error_o), 1);
        ack = 1; tick();
        settle("err_ack"); check("err_ack_d1", 32'(bus1.error_o), 1);
        do_reset();
        settle("post_rst"); check("post_rst_err", 32'(bus1.error_o), 0); tick();

        // asynchronous reset pulse between edges abandons a pending access
        req = 1; settle("aw0"); tick();
        settle("aw1");
        rst_n = 0; #1; rst_n = 1;
        model_reset();
        clr();
        settle("aw_rst");
        check("aw_rst_frz", 32'(bus1.freeze_o), 0);
        check("aw_rst_pc", 32'(bus1.pcWrite_o), 1);
        tick();

        // branch suppressed by load-use, then taken
        do_reset();
        idex_rd = 1; idex_rt = 3; rs = 3; br = 1;
        settle("br_lu"); check("br_lu_flush", 32'(bus1.IFIDFlush_o), 0); tick();
        idex_rd = 0;
        settle("br"); check("br_flush", 32'(bus1.IFIDFlush_o), 1); tick();
        clr();
        settle("br_done");
`ifdef HAZ_PERF_CNT_EN
        check("perf_stall", stall1, 1);
        check("perf_flush", flush1, 1);
`endif
        tick();

        // randomized traffic with periodic resets
        for (int n = 0; n < 400; n++) begin
            rst_n = (n % 50) != 49;
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            idex_rt = 5'($urandom_range(0, 7)); exmem_rt = 5'($urandom_range(0, 7));
            idex_rd = 1'($urandom); exmem_rd = 1'($urandom);
            req = ($urandom_range(0, 3) == 0); ack = 1'($urandom); br = 1'($urandom);
            settle("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
